// File: rtl/polygon_area_shoelace.sv
// rtl/polygon_area_shoelace.sv - streamed shoelace sum giving twice the area of a simple polygon
module polygon_area_shoelace #(
    parameter int W = 11,
    parameter int VMAX = 16,
    localparam int NW = $clog2(VMAX + 1),
    localparam int ACC_W = 2 * W + 1 + $clog2(VMAX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NW-1:0]       nverts,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] px,
    input  logic signed [W-1:0] py,
    output logic [ACC_W-1:0]    s,
    output logic                neg,
    output logic                err,
    output logic                valid,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_CLOSE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [NW-1:0]       nverts_q, nverts_d;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic signed [W-1:0] fx_q, fx_d, fy_q, fy_d;
    logic signed [W-1:0] prx_q, prx_d, pry_q, pry_d;
    logic [ACC_W-1:0]    s_q, s_d;
    logic                neg_q, neg_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;

    logic signed [W-1:0]   bx, by;
    logic signed [2*W-1:0] p1, p2;
    logic signed [2*W:0]   diff;
    logic [ACC_W-1:0]      diff_ext;
    logic                  nverts_ok;

    // The "current" vertex is the incoming one while loading, the first one when closing.
    always_comb begin
        bx = (state_q == ST_LOAD) ? px : fx_q;
        by = (state_q == ST_LOAD) ? py : fy_q;
        p1 = prx_q * by;
        p2 = bx * pry_q;
        diff = (2*W+1)'(p1) - (2*W+1)'(p2);
        diff_ext = {{(ACC_W-2*W-1){diff[2*W]}}, diff};
        nverts_ok = (nverts >= NW'(3)) && (nverts <= NW'(VMAX));
    end

    always_comb begin
        state_d  = state_q;
        nverts_d = nverts_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        prx_d    = prx_q;
        pry_d    = pry_q;
        s_d      = s_q;
        neg_d    = neg_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (nverts_ok) begin
                        nverts_d = nverts;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        s_d     = '0;
                        neg_d   = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    prx_d = px;
                    pry_d = py;
                    if (cnt_q == '0) begin
                        fx_d = px;
                        fy_d = py;
                    end else begin
                        acc_d = acc_q + diff_ext;
                    end
                    cnt_d = cnt_q + NW'(1);
                    if (cnt_q == nverts_q - NW'(1)) begin
                        state_d = ST_CLOSE;
                    end
                end
            end
            ST_CLOSE: begin
                acc_d   = acc_q + diff_ext;
                state_d = ST_FINISH;
            end
            default: begin
                s_d     = acc_q[ACC_W-1] ? (ACC_W'(0) - acc_q) : acc_q;
                neg_d   = acc_q[ACC_W-1];
                err_d   = 1'b0;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            nverts_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            prx_q    <= '0;
            pry_q    <= '0;
            s_q      <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            nverts_q <= nverts_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            prx_q    <= prx_d;
            pry_q    <= pry_d;
            s_q      <= s_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign s        = s_q;
    assign neg      = neg_q;
    assign err      = err_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_polygon_area_shoelace.sv
// tb/tb_polygon_area_shoelace.sv - directed-vector bench for polygon_area_shoelace
module tb_polygon_area_shoelace;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [4:0]         nverts;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] px, py;
    logic [26:0]        s;
    logic               neg, err, valid, busy;

    int tests_run = 0;
    int failed = 0;

    polygon_area_shoelace dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nverts(nverts),
        .in_valid(in_valid), .in_ready(in_ready), .px(px), .py(py),
        .s(s), .neg(neg), .err(err), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [4:0] n);
        start = 1'b1;
        nverts = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [10:0] x, input logic signed [10:0] y);
        int guard = 0;
        px = x; py = y; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            tests_run++; failed++;
            $display("FAIL feed_timeout: in_ready=%0b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        px = 11'sd333; py = -11'sd77;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if ({s, neg, err, valid, in_ready, busy} !== 33'd0) begin
            failed++;
            $display("FAIL reset_outputs: s=%0d neg=%0b err=%0b valid=%0b rdy=%0b busy=%0b want all 0",
                     s, neg, err, valid, in_ready, busy);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin failed++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_triangle;
        int k;
        do_start(5'd3);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failed++; $display("FAIL tri_load: rdy=%0b busy=%0b want 1 1", in_ready, busy);
        end
        feed(0, 0); feed(4, 0); feed(0, 3);
        wait_valid(k);
        tests_run++;
        if (k !== 3) begin failed++; $display("FAIL tri_latency: got %0d edges want 3", k); end
        tests_run++;
        if (valid !== 1'b1 || s !== 27'd12 || neg !== 1'b0 || err !== 1'b0) begin
            failed++; $display("FAIL tri_result: valid=%0b s=%0d neg=%0b err=%0b want 1 12 0 0", valid, s, neg, err);
        end
        @(posedge clk); #1;
        tests_run++;
        if (valid !== 1'b0 || s !== 27'd12) begin
            failed++; $display("FAIL tri_pulse_hold: valid=%0b s=%0d want 0 12", valid, s);
        end
    endtask

    task automatic test_reversed;
        int k;
        do_start(5'd3);
        feed(0, 0); feed(0, 3); feed(4, 0);
        wait_valid(k);
        tests_run++;
        if (valid !== 1'b1 || s !== 27'd12 || neg !== 1'b1 || err !== 1'b0) begin
            failed++; $display("FAIL rev_result: valid=%0b s=%0d neg=%0b err=%0b want 1 12 1 0", valid, s, neg, err);
        end
    endtask

    task automatic test_collinear;
        int k;
        do_start(5'd3);
        feed(0, 0); feed(1, 1); feed(2, 2);
        wait_valid(k);
        tests_run++;
        if (valid !== 1'b1 || s !== 27'd0 || neg !== 1'b0 || err !== 1'b0) begin
            failed++; $display("FAIL collinear: valid=%0b s=%0d neg=%0b err=%0b want 1 0 0 0", valid, s, neg, err);
        end
    endtask

    task automatic test_errors;
        logic [4:0] bad [2];
        bad[0] = 5'd2;
        bad[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            do_start(bad[i]);
            tests_run++;
            if (valid !== 1'b1 || err !== 1'b1 || s !== 27'd0 || neg !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL err_n%0d: valid=%0b err=%0b s=%0d neg=%0b busy=%0b want 1 1 0 0 0",
                         bad[i], valid, err, s, neg, busy);
            end
            @(posedge clk); #1;
            tests_run++;
            if (valid !== 1'b0 || err !== 1'b1 || in_ready !== 1'b0) begin
                failed++; $display("FAIL err_after_n%0d: valid=%0b err=%0b rdy=%0b want 0 1 0", bad[i], valid, err, in_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        int k;
        int idx = 0;
        bit rdy_ok = 1'b1;
        logic pat [6];
        logic signed [10:0] vx [3];
        logic signed [10:0] vy [3];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        vx[0] = 0; vy[0] = 0; vx[1] = 4; vy[1] = 0; vx[2] = 0; vy[2] = 3;
        do_start(5'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            px = pat[i] ? vx[idx] : 11'sd500;
            py = pat[i] ? vy[idx] : -11'sd500;
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            @(posedge clk); #1;
            if (pat[i]) idx++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (!rdy_ok) begin failed++; $display("FAIL bp_ready: in_ready dropped during LOAD, want held 1"); end
        tests_run++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_consumed: rdy=%0b after 3 vertices want 0", in_ready); end
        wait_valid(k);
        tests_run++;
        if (k !== 3 || valid !== 1'b1 || s !== 27'd12 || neg !== 1'b0 || err !== 1'b0) begin
            failed++; $display("FAIL bp_result: k=%0d valid=%0b s=%0d neg=%0b err=%0b want 3 1 12 0 0", k, valid, s, neg, err);
        end
    endtask

    task automatic test_square;
        int k;
        do_start(5'd4);
        feed(-1024, -1024); feed(1023, -1024); feed(1023, 1023); feed(-1024, 1023);
        wait_valid(k);
        tests_run++;
        if (k !== 3 || valid !== 1'b1 || s !== 27'd8380418 || neg !== 1'b0 || err !== 1'b0) begin
            failed++; $display("FAIL square: k=%0d valid=%0b s=%0d neg=%0b err=%0b want 3 1 8380418 0 0", k, valid, s, neg, err);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_valid = 1'b0;
        do_start(5'd4);
        feed(-1024, -1024); feed(1023, -1024);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s, neg, err, valid, in_ready, busy} !== 33'd0) begin
            failed++;
            $display("FAIL mid_reset: s=%0d neg=%0b err=%0b valid=%0b rdy=%0b busy=%0b want all 0",
                     s, neg, err, valid, in_ready, busy);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
        end
        tests_run++;
        if (saw_valid) begin failed++; $display("FAIL mid_reset_quiet: valid/busy seen after abort, want 0"); end
    endtask

    task automatic test_back_to_back;
        int k;
        do_start(5'd3);
        feed(0, 0); feed(0, 3); feed(4, 0);
        wait_valid(k);
        tests_run++;
        if (valid !== 1'b1 || s !== 27'd12 || neg !== 1'b1) begin
            failed++; $display("FAIL b2b_first: valid=%0b s=%0d neg=%0b want 1 12 1", valid, s, neg);
        end
        do_start(5'd4);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || valid !== 1'b0) begin
            failed++; $display("FAIL b2b_start: rdy=%0b busy=%0b valid=%0b want 1 1 0", in_ready, busy, valid);
        end
        feed(-1024, -1024); feed(1023, -1024); feed(1023, 1023); feed(-1024, 1023);
        wait_valid(k);
        tests_run++;
        if (k !== 3 || valid !== 1'b1 || s !== 27'd8380418 || neg !== 1'b0 || err !== 1'b0) begin
            failed++; $display("FAIL b2b_second: k=%0d valid=%0b s=%0d neg=%0b err=%0b want 3 1 8380418 0 0", k, valid, s, neg, err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        nverts = '0;
        in_valid = 1'b0;
        px = '0;
        py = '0;
        #2;
        test_reset;
        test_triangle;
        test_reversed;
        test_collinear;
        test_errors;
        test_backpressure;
        test_square;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
